// File: rtl/ifmap_row_loader_pkg.sv
// Shared constants, FSM encoding and helpers for the IF-map row loader.
package ifmap_row_loader_pkg;

  localparam int unsigned NUM_BANKS = 8;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DIM_W     = 6;
  localparam int unsigned K_W       = 4;
  localparam int unsigned OFF_W     = 3;          // log2(NUM_BANKS): bank offset width
  localparam int unsigned WPR_W     = DIM_W - 2;  // words per row: ceil(63/8)=8 needs 4 bits
  localparam int unsigned KROW_W    = 3;
  localparam int unsigned SEL_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_LOAD    = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  // Words per image row in each bank: (W+7)>>3.
  function automatic logic [WPR_W-1:0] calc_wpr(input logic [DIM_W-1:0] w);
    logic [DIM_W:0] s;
    s = {1'b0, w} + (DIM_W+1)'(7);
    return WPR_W'(s >> OFF_W);
  endfunction

endpackage

// File: rtl/ifmap_row_loader_addr_gen.sv
// Combinational bank address / enable / mux-select map for one window row.
module ifmap_addr_gen
  import ifmap_row_loader_pkg::*;
(
  input  logic [DIM_W-1:0]            i_x0,
  input  logic [DIM_W-1:0]            i_y,
  input  logic [K_W-1:0]              i_k,
  input  logic [WPR_W-1:0]            i_wpr,
  output logic [NUM_BANKS-1:0]        o_rd_en,
  output logic [NUM_BANKS*ADDR_W-1:0] o_rd_addr,
  output logic [SEL_W*NUM_REGS-1:0]   o_mux_sel
);

  logic [ADDR_W-1:0] w_row_base;
  logic [OFF_W-1:0]  w_off;
  logic [DIM_W:0]    w_col;

  // Bank b holds column x0+off where off=(b-x0) mod 8; only the first K columns are read.
  always_comb begin
    o_rd_en    = '0;
    o_rd_addr  = '0;
    o_mux_sel  = '0;
    w_off      = '0;
    w_col      = '0;
    w_row_base = ADDR_W'(i_y) * ADDR_W'(i_wpr);
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_off = OFF_W'(b) - i_x0[OFF_W-1:0];
      w_col = (DIM_W+1)'(i_x0) + (DIM_W+1)'(w_off);
      if (K_W'(w_off) < i_k) begin
        o_rd_en[b]                    = 1'b1;
        o_rd_addr[b*ADDR_W +: ADDR_W] = w_row_base + ADDR_W'(w_col >> OFF_W);
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (K_W'(i) < i_k) begin
        o_mux_sel[i*SEL_W +: SEL_W] = i_x0[OFF_W-1:0] + OFF_W'(i);
      end
    end
  end

endmodule

// File: rtl/ifmap_row_loader.sv
// K x K window sequencer: drives bank reads, register loads and row handshake.
module ifmap_row_loader
  import ifmap_row_loader_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [K_W-1:0]              i_kernel_size,
  input  logic [DIM_W-1:0]            i_img_width,
  input  logic [DIM_W-1:0]            i_img_height,
  output logic [NUM_BANKS-1:0]        o_rd_en,
  output logic [NUM_BANKS*ADDR_W-1:0] o_rd_addr,
  output logic [NUM_REGS-1:0]         o_reg_loads,
  output logic [SEL_W*NUM_REGS-1:0]   o_mux_sel,
  output logic [NUM_REGS-1:0]         o_local_reset,
  output logic                        o_row_valid,
  input  logic                        i_row_ready,
  output logic [KROW_W-1:0]           o_kernel_row,
  output logic [DIM_W-1:0]            o_out_x,
  output logic [DIM_W-1:0]            o_out_y,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_cfg_err
);

  state_e             r_state, w_state_nxt;
  logic [K_W-1:0]     r_k, w_k_nxt;
  logic [DIM_W-1:0]   r_w, w_w_nxt;
  logic [DIM_W-1:0]   r_h, w_h_nxt;
  logic [KROW_W-1:0]  r_ky, w_ky_nxt;
  logic [DIM_W-1:0]   r_ox, w_ox_nxt;
  logic [DIM_W-1:0]   r_oy, w_oy_nxt;

  logic w_legal, w_hs, w_last_ky, w_last_x, w_last_y, w_last;

  logic [NUM_BANKS-1:0]        w_gen_en;
  logic [NUM_BANKS*ADDR_W-1:0] w_gen_addr;
  logic [SEL_W*NUM_REGS-1:0]   w_gen_sel;
  logic [NUM_REGS-1:0]         w_load_mask;

  logic [NUM_BANKS-1:0]        w_rd_en_d;
  logic [NUM_BANKS*ADDR_W-1:0] w_rd_addr_d;
  logic [NUM_REGS-1:0]         w_reg_loads_d;
  logic [SEL_W*NUM_REGS-1:0]   w_mux_sel_d;
  logic [NUM_REGS-1:0]         w_local_reset_d;
  logic                        w_row_valid_d, w_busy_d, w_done_d, w_cfg_err_d;

  // Config legality and end-of-map detection.
  always_comb begin
    w_legal   = (i_kernel_size != '0) &&
                (i_kernel_size <= K_W'(NUM_REGS)) &&
                (DIM_W'(i_kernel_size) <= i_img_width) &&
                (DIM_W'(i_kernel_size) <= i_img_height);
    w_hs      = (r_state == ST_PRESENT) && i_row_ready;
    w_last_ky = (K_W'(r_ky) == r_k - K_W'(1));
    w_last_x  = (r_ox == r_w - DIM_W'(r_k));
    w_last_y  = (r_oy == r_h - DIM_W'(r_k));
    w_last    = w_last_ky && w_last_x && w_last_y;
  end

  // State, latched config and window counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_ky    <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_w     <= w_w_nxt;
      r_h     <= w_h_nxt;
      r_ky    <= w_ky_nxt;
      r_ox    <= w_ox_nxt;
      r_oy    <= w_oy_nxt;
    end
  end

  // Next state, config capture and counter advance (ky innermost, then x, then y).
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_w_nxt     = r_w;
    w_h_nxt     = r_h;
    w_ky_nxt    = r_ky;
    w_ox_nxt    = r_ox;
    w_oy_nxt    = r_oy;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start && w_legal) begin
          w_state_nxt = ST_READ;
          w_k_nxt     = i_kernel_size;
          w_w_nxt     = i_img_width;
          w_h_nxt     = i_img_height;
          w_ky_nxt    = '0;
          w_ox_nxt    = '0;
          w_oy_nxt    = '0;
        end
      end
      ST_READ: w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_PRESENT;
      ST_PRESENT: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_READ;
            if (w_last_ky) begin
              w_ky_nxt = '0;
              if (w_last_x) begin
                w_ox_nxt = '0;
                w_oy_nxt = r_oy + DIM_W'(1);
              end else begin
                w_ox_nxt = r_ox + DIM_W'(1);
              end
            end else begin
              w_ky_nxt = r_ky + KROW_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  ifmap_addr_gen u_addr_gen (
    .i_x0      (w_ox_nxt),
    .i_y       (w_oy_nxt + DIM_W'(w_ky_nxt)),
    .i_k       (w_k_nxt),
    .i_wpr     (calc_wpr(w_w_nxt)),
    .o_rd_en   (w_gen_en),
    .o_rd_addr (w_gen_addr),
    .o_mux_sel (w_gen_sel)
  );

  // Output decode from the upcoming state so every output is a plain flop.
  always_comb begin
    w_rd_en_d       = '0;
    w_rd_addr_d     = '0;
    w_reg_loads_d   = '0;
    w_mux_sel_d     = '0;
    w_local_reset_d = '0;
    w_row_valid_d   = 1'b0;
    w_load_mask     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_load_mask[i] = (K_W'(i) < w_k_nxt);
    end
    unique case (w_state_nxt)
      ST_READ: begin
        w_rd_en_d   = w_gen_en;
        w_rd_addr_d = w_gen_addr;
      end
      ST_LOAD: begin
        w_reg_loads_d   = w_load_mask;
        w_local_reset_d = ~w_load_mask;
        w_mux_sel_d     = w_gen_sel;
      end
      ST_PRESENT: w_row_valid_d = 1'b1;
      default: ;
    endcase
    w_busy_d    = (w_state_nxt != ST_IDLE);
    w_done_d    = w_hs && w_last;
    w_cfg_err_d = (r_state == ST_IDLE) && i_start && !w_legal;
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_en       <= '0;
      o_rd_addr     <= '0;
      o_reg_loads   <= '0;
      o_mux_sel     <= '0;
      o_local_reset <= '0;
      o_row_valid   <= 1'b0;
      o_kernel_row  <= '0;
      o_out_x       <= '0;
      o_out_y       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_cfg_err     <= 1'b0;
    end else begin
      o_rd_en       <= w_rd_en_d;
      o_rd_addr     <= w_rd_addr_d;
      o_reg_loads   <= w_reg_loads_d;
      o_mux_sel     <= w_mux_sel_d;
      o_local_reset <= w_local_reset_d;
      o_row_valid   <= w_row_valid_d;
      o_kernel_row  <= w_ky_nxt;
      o_out_x       <= w_ox_nxt;
      o_out_y       <= w_oy_nxt;
      o_busy        <= w_busy_d;
      o_done        <= w_done_d;
      o_cfg_err     <= w_cfg_err_d;
    end
  end

endmodule

// File: doc/ifmap_row_loader.md
# ifmap_row_loader

Upstream sequencer for the IF-map register array. It walks a K×K convolution window across an input feature map held in 8 interleaved SRAM banks. Each cycle it drives bank read addresses/enables and then the per-register load, mux-select and local-reset controls, so that each IF-map register captures one window pixel per kernel row. Each loaded row is offered downstream (MAC array) through a valid/ready handshake.

## Interface
- NUM_REGS, 8, IF-map registers driven (= banks, max K)
- ADDR_W, 10, bank address width
- DIM_W, 6, image dimension width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a map
- kernel_size  in  4  K, legal 1..8
- img_width  in  DIM_W  W, pixels per row
- img_height  in  DIM_W  H, rows
- rd_en  out  8  per-bank SRAM read enable
- rd_addr  out  8*ADDR_W  bank b address at [b*ADDR_W +: ADDR_W]
- reg_loads  out  NUM_REGS  per-register load enable
- mux_sel  out  3*NUM_REGS  register i bank select at [3i +: 3]
- local_reset  out  NUM_REGS  clear unused registers
- row_valid  out  1  loaded row available
- row_ready  in  1  consumer accepts row
- kernel_row  out  3  ky of presented row
- out_x, out_y  out  DIM_W each  window origin of presented row
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after last row accepted
- cfg_err  out  1  one-cycle pulse, start rejected

## Operation
- Memory map: pixel (y,x) is in bank x%8 at address y*WPR + (x>>3), with WPR = (W+7)>>3. Address math is ADDR_W wide and truncates.
- Loop order: out_y 0..H-K, out_x 0..W-K, ky 0..K-1 (ky innermost). Stride 1.
- FSM states: IDLE, READ, LOAD, PRESENT.
- IDLE: on start with 1≤K≤8, K≤W, K≤H → latch K/W/H, zero counters, go to READ. On an illegal config → pulse cfg_err, stay in IDLE. start outside IDLE is ignored.
- READ (1 cycle): row y = out_y+ky, columns x0 = out_x … x0+K-1. Bank b: off = (b − x0) mod 8. If off < K, set rd_en[b]=1 and rd_addr = y*WPR + ((x0+off)>>3). Otherwise rd_en[b]=0 and rd_addr=0. Go to LOAD.
- LOAD (1 cycle, SRAM data valid): for i<K, set reg_loads[i]=1 and mux_sel[i] = (x0+i)%8. For i≥K, set local_reset[i]=1 and reg_loads[i]=0. Go to PRESENT.
- PRESENT: row_valid=1 with kernel_row/out_x/out_y stable. On row_valid&row_ready:
  - if this was the last ky of the last window → pulse done, go to IDLE;
  - otherwise advance the counters (ky wraps to 0 → out_x++; out_x wraps past W−K → 0 and out_y++) and go to READ.
- The latched config is unaffected by input changes while busy.

## Timing
- Reset (async): state IDLE. rd_en, rd_addr, reg_loads, mux_sel, local_reset, row_valid, kernel_row, out_x, out_y, busy, done and cfg_err all go to 0.
- Reset mid-map abandons the map. No done is produced.
- All outputs are registered-state decodes, with no combinational path from row_ready.
- start at cycle n → READ at n+1, LOAD at n+2, row_valid first high at n+3.
- Minimum 3 cycles per row. Each cycle of row_ready low adds one cycle.
- Total rows = (H−K+1)*(W−K+1)*K.
- rd_en is high only in READ. reg_loads/local_reset are high only in LOAD. row_valid is high only in PRESENT.
- done is asserted in the cycle after the final handshake, which is also the first cycle back in IDLE. busy is low in that cycle. A start in that same cycle is accepted.
- K=W (single column position) and K=H are legal. K=1 loads only register 0.

## Structure
- Shared package: state encoding, NUM_BANKS=8, and the bank-offset/WPR width constants.
- A single sub-module, ifmap_addr_gen, is natural: a combinational map from (x0, y, K, WPR) to rd_en/rd_addr/mux_sel. The FSM and counters stay in the top level.

## Test plan
- Reset mid-PRESENT with row_valid=1 → all outputs 0 immediately. A new start then works normally.
- W=8, H=3, K=3, row_ready tied 1: 18 rows. First READ: rd_en=8'b00000111, all addresses 0. First LOAD: reg_loads=8'h07, local_reset=8'hF8, mux_sel regs 0..2 = 0,1,2. done pulses 54 cycles after the first READ.
- W=16, H=3, K=3, window out_x=6, ky=1: rd_en banks 6,7,0 high. Addresses are bank6=2, bank7=2, bank0=3. mux_sel = 6,7,0.
- Backpressure: row_ready low 5 cycles in PRESENT → row_valid and kernel_row/out_x/out_y held. No new rd_en until the handshake.
- K=0, K=9, and K=5 with W=4 → cfg_err pulse for each, busy stays 0, no rd_en.
- K=8, W=8, H=8: single window, 8 rows. reg_loads=8'hFF and local_reset=0 every LOAD. done after 8 handshakes.
